mux_nx1_rr: RTL and testbench
=============================

# mux_nx1_rr

Registered N-channel, W-bit multiplexer with valid/ready handshakes and two selection modes: externally selected (`mode`=0) or round-robin among requesting channels (`mode`=1). It generalises the 4:1 single-bit gate-level mux into a buffered stream selector. It sits between several producer streams and a single consumer, giving one word per cycle throughput with a one-entry output register.

## Interface
- `N`, 4, number of input channels; legal range N ≥ 2.
- `W`, 4, data width per channel in bits.
- `SW`, $clog2(N), width of channel index; localparam, not overridable.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  1  0 = fixed select by `sel`; 1 = round-robin.
- `sel`  in  SW  channel index used when `mode`=0.
- `in_data`  in  N*W  channel i occupies bits [i*W +: W].
- `in_valid`  in  N  per-channel request.
- `in_ready`  out  N  per-channel accept; combinational; at most one bit high.
- `out_data`  out  W  registered selected word.
- `out_sel`  out  SW  registered index of the channel that supplied `out_data`.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts the word.

## Operation
- **Reset values:** `out_valid`=0, `out_data`=0, `out_sel`=0, round-robin pointer `ptr`=0. Reset takes priority over every other event, including a pending output word, which is discarded.
- **Output space:** `space` = !`out_valid` | `out_ready`.
- **Grant, `mode`=0:**
  - `gnt` = `sel`.
  - `gnt_v` = `in_valid[sel]`.
  - If `sel` ≥ N (N not a power of 2), `gnt_v`=0.
- **Grant, `mode`=1:**
  - `gnt` = first index j scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N) with `in_valid[j]`=1.
  - `gnt_v` = |`in_valid`.
  - `sel` is ignored.
- **Accept:** `in_ready[i]` = `space` & `gnt_v` & (`gnt`==i). A transfer on channel i occurs when `in_valid[i]` & `in_ready[i]`.
- **On transfer:** `out_data` <= channel `gnt` word, `out_sel` <= `gnt`, `out_valid` <= 1.
- **Without transfer:**
  - If `out_ready` & `out_valid`, then `out_valid` <= 0.
  - `out_data` and `out_sel` hold.
- **Pointer update:**
  - `ptr` <= (`gnt`+1) mod N only on a transfer in `mode`=1. Wrap: `gnt`=N-1 gives `ptr`=0.
  - `ptr` holds in `mode`=0 and is not reset by mode changes.
- **Mode and `sel`:** sampled every cycle and may change any cycle; they take effect on the grant in the same cycle. A word already in the output register is unaffected.
- **Data rules:** the block never modifies data, with no width conversion. No input is accepted unless its `in_valid` is high. Inputs not granted see `in_ready`=0 and must hold.

## Timing
- Latency: 1 cycle from accepted input word to `out_valid`/`out_data`.
- Throughput: 1 word/cycle when `out_ready` is held high.
- Simultaneous drain and load (`out_valid`=1, `out_ready`=1, `gnt_v`=1): old word leaves, new word loads in the same edge, and `out_valid` stays 1.
- Backpressure (`out_valid`=1, `out_ready`=0):
  - All `in_ready`=0.
  - `out_data`/`out_sel` stable.
  - `ptr` holds.
- `in_ready` depends combinationally on `in_valid`, `mode`, `sel`, `out_valid`, `out_ready`. Producers must not make `in_valid` depend on `in_ready`.
- Round-robin fairness: with all N channels continuously valid and `out_ready`=1, grants cycle 0,1,…,N-1,0 with no channel starved for more than N-1 transfers.

## Test plan
All scenarios use N=4, W=4.
1. **Reset:** hold `rst` 2 cycles with all `in_valid`=1 → `out_valid`=0, `out_data`=0, `out_sel`=0, `in_ready`=0000 during reset. First grant after release is channel 0 in `mode`=1.
2. **Fixed mode:** `mode`=0, `sel`=2, `in_data`={3:0xD, 2:0xA, 1:0x5, 0:0x1}, `in_valid`=1111, `out_ready`=1 → `in_ready`=0100, next cycle `out_data`=0xA, `out_sel`=2. `in_valid[2]`=0 → `in_ready`=0000 and `out_valid` drops after 1 cycle.
3. **Round-robin wrap:** `mode`=1, `in_valid`=1111, `out_ready`=1 for 6 cycles → `out_sel` sequence 0,1,2,3,0,1. Then `in_valid`=1001 with `ptr`=2 → grant 3, then 0.
4. **Backpressure:** `out_valid`=1 holding 0x5, `out_ready`=0 for 3 cycles → `out_data`=0x5 stable, `in_ready`=0000, `ptr` unchanged. Raise `out_ready` with `in_valid[3]`=1 (data 0xD) → same edge loads 0xD, `out_valid` stays 1.
5. **Mode switch:** after round-robin leaves `ptr`=3, switch to `mode`=0, `sel`=1 for 2 transfers → `out_sel`=1,1. Switch back to `mode`=1 with all valid → next grant 3.
6. **Reset mid-operation:** `rst` asserted while `out_valid`=1, `out_ready`=0 → next cycle `out_valid`=0, `ptr`=0, and the word is lost.

Source files
------------

// File: rtl/mux_nx1_rr_if.sv
// Stream bundle for mux_nx1_rr: N producer channels in, one registered word out.
// master = producer/consumer side, slave = the mux itself.
interface mux_nx1_rr_if #(
    parameter int N = 4,
    parameter int W = 4
);
    localparam int SW = $clog2(N);

    logic              mode;
    logic [SW-1:0]     sel;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [W-1:0]      out_data;
    logic [SW-1:0]     out_sel;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/mux_nx1_rr.sv
// Registered N:1 stream selector: fixed select (mode=0) or round-robin among
// requesting channels (mode=1), with a one-entry output register.
module mux_nx1_rr #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    mux_nx1_rr_if.slave  bus
);
    localparam int SW = $clog2(N);

    logic [SW-1:0] ptr;
    logic [SW-1:0] gnt;
    logic          gnt_v;
    logic          space;
    logic          xfer;

    // Nothing is offered to producers while reset is held.
    assign space = !rst && (!bus.out_valid || bus.out_ready);
    assign xfer  = space && gnt_v;

    always_comb begin
        int idx;
        gnt   = '0;
        gnt_v = 1'b0;
        idx   = 0;
        if (!bus.mode) begin
            if (int'(bus.sel) < N) begin
                gnt   = bus.sel;
                gnt_v = bus.in_valid[bus.sel];
            end
        end else begin
            // Scan from ptr upward with wrap; first requester wins.
            for (int k = 0; k < N; k++) begin
                idx = (int'(ptr) + k) % N;
                if (!gnt_v && bus.in_valid[idx]) begin
                    gnt   = SW'(idx);
                    gnt_v = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        if (xfer) begin
            bus.in_ready[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
            ptr           <= '0;
        end else begin
            if (xfer) begin
                bus.out_data  <= bus.in_data[int'(gnt)*W +: W];
                bus.out_sel   <= gnt;
                bus.out_valid <= 1'b1;
                if (bus.mode) begin
                    if (int'(gnt) == N-1) begin
                        ptr <= '0;
                    end else begin
                        ptr <= gnt + SW'(1);
                    end
                end
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_nx1_rr.sv
// Self-checking bench for mux_nx1_rr: directed scenarios plus a randomized run
// against a behavioural model of the selector.
module tb_mux_nx1_rr;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int SW = $clog2(N);

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    mux_nx1_rr_if #(.N(N), .W(W)) bus ();

    mux_nx1_rr #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic [SW-1:0] m_sel;
    int            m_ptr;

    // Grant chosen by rule: fixed sel, or requester closest after ptr (mod N).
    task automatic model_grant(output int g, output bit gv);
        int best;
        g    = 0;
        gv   = 1'b0;
        best = N;
        if (!bus.mode) begin
            g  = int'(bus.sel);
            gv = (g < N) && bus.in_valid[g];
        end else begin
            for (int j = 0; j < N; j++) begin
                if (bus.in_valid[j] && ((j - m_ptr + N) % N) < best) begin
                    best = (j - m_ptr + N) % N;
                    g    = j;
                end
            end
            gv = (best < N);
        end
    endtask

    task automatic exp_ready(output logic [N-1:0] r);
        int g;
        bit gv;
        model_grant(g, gv);
        r = '0;
        if (!rst && (!m_valid || bus.out_ready) && gv) r[g] = 1'b1;
    endtask

    task automatic tick();
        int g;
        bit gv;
        bit xfer;
        model_grant(g, gv);
        xfer = !rst && (!m_valid || bus.out_ready) && gv;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = '0;
            m_ptr   = 0;
        end else if (xfer) begin
            m_data  = bus.in_data[g*W +: W];
            m_sel   = SW'(g);
            m_valid = 1'b1;
            if (bus.mode) m_ptr = (g + 1) % N;
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [N-1:0] er;
        rst = 1'b1;
        bus.mode = 1'b1; bus.sel = '0; bus.in_valid = 4'b1111;
        bus.in_data = 16'hDA51; bus.out_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready_pre got=%b exp=0000", bus.in_ready); end
        tick();
        tests_run++;
        if (bus.in_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready_hold got=%b exp=0000", bus.in_ready); end
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.out_sel !== 2'd0) begin
            tests_failed++; $display("FAIL reset_outputs got v=%b d=%h s=%0d exp v=0 d=0 s=0", bus.out_valid, bus.out_data, bus.out_sel);
        end
        rst = 1'b0;
        #1;
        exp_ready(er);
        tests_run++;
        if (bus.in_ready !== 4'b0001 || er !== 4'b0001) begin tests_failed++; $display("FAIL reset_first_ready got=%b exp=0001", bus.in_ready); end
        tick();
        tests_run++;
        if (bus.out_sel !== 2'd0 || bus.out_data !== 4'h1 || bus.out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL reset_first_grant got s=%0d d=%h v=%b exp s=0 d=1 v=1", bus.out_sel, bus.out_data, bus.out_valid);
        end
    endtask

    task automatic test_fixed();
        bus.mode = 1'b0; bus.sel = 2'd2; bus.in_data = 16'hDA51;
        bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== 4'b0100) begin tests_failed++; $display("FAIL fixed_ready got=%b exp=0100", bus.in_ready); end
        tick();
        tests_run++;
        if (bus.out_data !== 4'hA || bus.out_sel !== 2'd2 || bus.out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL fixed_out got d=%h s=%0d v=%b exp d=a s=2 v=1", bus.out_data, bus.out_sel, bus.out_valid);
        end
        bus.in_valid = 4'b1011;
        #1;
        tests_run++;
        if (bus.in_ready !== 4'b0000) begin tests_failed++; $display("FAIL fixed_idle_ready got=%b exp=0000", bus.in_ready); end
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 4'hA) begin
            tests_failed++; $display("FAIL fixed_drain got v=%b d=%h exp v=0 d=a", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_rr_wrap();
        int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
        rst = 1'b1; tick(); rst = 1'b0;
        bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b1; bus.in_data = 16'hDA51;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if (int'(bus.out_sel) !== exp_seq[i] || bus.out_valid !== 1'b1) begin
                tests_failed++; $display("FAIL rr_seq[%0d] got s=%0d v=%b exp s=%0d v=1", i, bus.out_sel, bus.out_valid, exp_seq[i]);
            end
        end
        bus.in_valid = 4'b1001;
        tick();
        tests_run++;
        if (bus.out_sel !== 2'd3 || bus.out_data !== 4'hD) begin tests_failed++; $display("FAIL rr_skip got s=%0d d=%h exp s=3 d=d", bus.out_sel, bus.out_data); end
        tick();
        tests_run++;
        if (bus.out_sel !== 2'd0 || bus.out_data !== 4'h1) begin tests_failed++; $display("FAIL rr_wrap got s=%0d d=%h exp s=0 d=1", bus.out_sel, bus.out_data); end
    endtask

    task automatic test_backpressure();
        // ptr is 1 here; load 0x5 from channel 1 in fixed mode (ptr untouched)
        bus.mode = 1'b0; bus.sel = 2'd1; bus.in_valid = 4'b0010; bus.out_ready = 1'b1;
        tick();
        bus.mode = 1'b1; bus.in_valid = 4'b1111; bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (bus.in_ready !== 4'b0000) begin tests_failed++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, bus.in_ready); end
            tick();
            tests_run++;
            if (bus.out_data !== 4'h5 || bus.out_valid !== 1'b1 || bus.out_sel !== 2'd1) begin
                tests_failed++; $display("FAIL bp_hold[%0d] got d=%h v=%b s=%0d exp d=5 v=1 s=1", i, bus.out_data, bus.out_valid, bus.out_sel);
            end
        end
        // Release with only channel 3 requesting: drain and load on one edge
        bus.out_ready = 1'b1; bus.in_valid = 4'b1000;
        #1;
        tests_run++;
        if (bus.in_ready !== 4'b1000) begin tests_failed++; $display("FAIL bp_release_ready got=%b exp=1000", bus.in_ready); end
        tick();
        tests_run++;
        if (bus.out_data !== 4'hD || bus.out_valid !== 1'b1 || bus.out_sel !== 2'd3) begin
            tests_failed++; $display("FAIL bp_release got d=%h v=%b s=%0d exp d=d v=1 s=3", bus.out_data, bus.out_valid, bus.out_sel);
        end
    endtask

    task automatic test_ptr_held();
        // A stall in mode 1 must not advance ptr: with ptr at 1, all valid grants 1
        rst = 1'b1; tick(); rst = 1'b0;
        bus.mode = 1'b1; bus.in_valid = 4'b0001; bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 4'b1111;
        tick(); tick();
        bus.out_ready = 1'b1;
        tick();
        tests_run++;
        if (bus.out_sel !== 2'd1 || bus.out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL ptr_held got s=%0d v=%b exp s=1 v=1", bus.out_sel, bus.out_valid);
        end
    endtask

    task automatic test_mode_switch();
        bus.mode = 1'b1; bus.in_valid = 4'b0100; bus.out_ready = 1'b1;
        tick();
        bus.mode = 1'b0; bus.sel = 2'd1; bus.in_valid = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if (bus.out_sel !== 2'd1 || bus.out_data !== 4'h5) begin
                tests_failed++; $display("FAIL mode_fixed[%0d] got s=%0d d=%h exp s=1 d=5", i, bus.out_sel, bus.out_data);
            end
        end
        bus.mode = 1'b1;
        tick();
        tests_run++;
        if (bus.out_sel !== 2'd3 || bus.out_data !== 4'hD) begin tests_failed++; $display("FAIL mode_back_rr got s=%0d d=%h exp s=3 d=d", bus.out_sel, bus.out_data); end
    endtask

    task automatic test_reset_mid();
        bus.mode = 1'b1; bus.in_valid = 4'b0010; bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0; bus.in_valid = 4'b1111;
        rst = 1'b1;
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.out_sel !== 2'd0) begin
            tests_failed++; $display("FAIL rst_mid got v=%b d=%h s=%0d exp v=0 d=0 s=0", bus.out_valid, bus.out_data, bus.out_sel);
        end
        rst = 1'b0; bus.out_ready = 1'b1;
        tick();
        tests_run++;
        if (bus.out_sel !== 2'd0 || bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_ptr got s=%0d v=%b exp s=0 v=1", bus.out_sel, bus.out_valid); end
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 39) == 0);
            bus.mode      = 1'($urandom_range(0, 1));
            bus.sel       = SW'($urandom_range(0, N-1));
            bus.in_valid  = N'($urandom);
            bus.in_data   = (N*W)'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready(er);
            tests_run++;
            if (bus.in_ready !== er) begin tests_failed++; $display("FAIL rand_ready[%0d] got=%b exp=%b", i, bus.in_ready, er); end
            tick();
            tests_run++;
            if (bus.out_valid !== m_valid || (m_valid && (bus.out_data !== m_data || bus.out_sel !== m_sel))) begin
                tests_failed++;
                $display("FAIL rand_out[%0d] got v=%b d=%h s=%0d exp v=%b d=%h s=%0d", i, bus.out_valid, bus.out_data, bus.out_sel, m_valid, m_data, m_sel);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_valid = 1'b0; m_data = '0; m_sel = '0; m_ptr = 0;
        rst = 1'b1;
        bus.mode = 1'b0; bus.sel = '0; bus.in_data = '0; bus.in_valid = '0; bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_fixed();
        test_rr_wrap();
        test_backpressure();
        test_ptr_held();
        test_mode_switch();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
